i2c_pad_filter: RTL

Pad-side conditioning stage placed between the board's bidirectional I2C pins and the I2C master core of the OLED character display design. Synchronizes and glitch-filters the raw SCL/SDA pad inputs before they reach the core. Registers the core's open-drain enables toward the pads. Reports bus START/STOP events and bus-busy status, and optionally detects SDA arbitration loss.

---
 rtl/i2c_pad_pkg.sv | 9 +
 rtl/i2c_glitch_filter.sv | 32 +++
 rtl/i2c_pad_filter.sv | 71 +++++++
 3 files changed

// File: rtl/i2c_pad_pkg.sv
// i2c_pad_pkg: shared constants for the I2C pad conditioning stage.
package i2c_pad_pkg;
    localparam int FILTER_LEN_DEF = 4;
    localparam int SCL = 0;
    localparam int SDA = 1;
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction
endpackage

// File: rtl/i2c_glitch_filter.sv
// i2c_glitch_filter: two-flop synchronizer plus run-length glitch filter for one I2C line.
module i2c_glitch_filter
    import i2c_pad_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic filt
);
    localparam int CW = cnt_width(FILTER_LEN);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], pad};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= ~filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_pad_filter.sv
// i2c_pad_filter: filters SCL/SDA pads, registers open-drain enables, flags START/STOP/busy.
// Define I2C_PAD_FILTER_ARB_EN to add the arb_lost arbitration-loss output.
module i2c_pad_filter
    import i2c_pad_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    input  logic scl_core_o,
    input  logic scl_core_oen,
    input  logic sda_core_o,
    input  logic sda_core_oen,
    output logic scl_filt,
    output logic sda_filt,
    output logic scl_pad_oen,
    output logic sda_pad_oen,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
`ifdef I2C_PAD_FILTER_ARB_EN
    ,
    output logic arb_lost
`endif
);
    logic [1:0] pad, filt;
    logic       scl_q, sda_q, start_c, stop_c;
    assign pad[SCL] = scl_pad_i;
    assign pad[SDA] = sda_pad_i;
    for (genvar i = 0; i < 2; i++) begin : g_line
        i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk   (clk),
            .reset (reset),
            .pad   (pad[i]),
            .filt  (filt[i])
        );
    end
    assign scl_filt = filt[SCL];
    assign sda_filt = filt[SDA];
    // SCL must be high on both cycles, so a simultaneous SCL/SDA flip is never an event
    assign start_c  = scl_q & scl_filt & sda_q & ~sda_filt;
    assign stop_c   = scl_q & scl_filt & ~sda_q & sda_filt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            scl_pad_oen <= 1'b1;
            sda_pad_oen <= 1'b1;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            bus_busy    <= 1'b0;
        end else begin
            scl_q       <= scl_filt;
            sda_q       <= sda_filt;
            scl_pad_oen <= scl_core_oen | scl_core_o;
            sda_pad_oen <= sda_core_oen | sda_core_o;
            start_det   <= start_c;
            stop_det    <= stop_c;
            bus_busy    <= start_c | (bus_busy & ~stop_c);
        end
    end
`ifdef I2C_PAD_FILTER_ARB_EN
    // core released SDA yet the bus reads low on an SCL rise: another master won
    always_ff @(posedge clk or posedge reset) begin
        if (reset) arb_lost <= 1'b0;
        else       arb_lost <= ~scl_q & scl_filt & (sda_core_oen | sda_core_o) & ~sda_filt & bus_busy;
    end
`endif
endmodule
